// File: rtl/arb_pkg.sv
// Shared state encoding, default sizing and small helpers for the
// round-robin grant controller.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_MIN_LAT  = 2;
  localparam int DEF_MAX_LAT  = 5;
  localparam int DEF_MAX_HOLD = 8;

  // Index increment that wraps from n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational round-robin picker: first set bit of req_mask_i found when
// scanning upward from rr_ptr_i and wrapping past the top index.
module arb_rr_picker
  import arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req_mask_i,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
  output logic                       valid_o,
  output logic [$clog2(NUM_REQ)-1:0] index_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    int cand;
    valid_o = 1'b0;
    index_o = '0;
    cand    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr_i) + k) % NUM_REQ;
      if (req_mask_i[IDX_W'(cand)]) begin
        valid_o = 1'b1;
        index_o = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/arb_grant_ctrl.sv
// Round-robin grant controller with a fixed request-to-grant latency,
// bounded grant hold time and per-master latency-violation flags.
module arb_grant_ctrl
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int MIN_LAT  = DEF_MIN_LAT,
  parameter int MAX_LAT  = DEF_MAX_LAT,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o,
  output logic [NUM_REQ-1:0]         lat_err_o
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int WAIT_W = $clog2(MIN_LAT);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int AGE_W  = $clog2(MAX_LAT + 2);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MIN_LAT - 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [AGE_W-1:0]  AGE_MAX   = AGE_W'(MAX_LAT + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MIN_LAT < 2 || MIN_LAT > MAX_LAT ||
      MAX_HOLD < 1) begin : g_bad_params
    $error("arb_grant_ctrl: illegal NUM_REQ/MIN_LAT/MAX_LAT/MAX_HOLD combination");
  end

  arb_state_e                     state_q, state_d;
  logic [IDX_W-1:0]               winner_q, winner_d;
  logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [WAIT_W-1:0]              wait_cnt_q, wait_cnt_d;
  logic [HOLD_W-1:0]              hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0]             grant_q, grant_d;
  logic [IDX_W-1:0]               grant_id_q, grant_id_d;
  logic                           busy_q, busy_d;
  logic [NUM_REQ-1:0]             lat_err_q, lat_err_d;
  logic [NUM_REQ-1:0][AGE_W-1:0]  age_q, age_d;

  logic [NUM_REQ-1:0]             winner_oh;
  logic [IDX_W-1:0]               next_ptr;
  logic [NUM_REQ-1:0]             pick_mask;
  logic [IDX_W-1:0]               pick_ptr;
  logic                           pick_valid;
  logic [IDX_W-1:0]               pick_idx;

  // While granting, the picker looks for the next winner with the current
  // holder masked out, which also pushes a forced-released master to the back.
  always_comb begin
    winner_oh           = '0;
    winner_oh[winner_q] = 1'b1;
    next_ptr            = IDX_W'(wrap_inc(int'(winner_q), NUM_REQ));
    if (state_q == GRANT) begin
      pick_mask = req_i & ~winner_oh;
      pick_ptr  = next_ptr;
    end else begin
      pick_mask = req_i;
      pick_ptr  = rr_ptr_q;
    end
  end

  arb_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_mask_i (pick_mask),
    .rr_ptr_i   (pick_ptr),
    .valid_o    (pick_valid),
    .index_o    (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = WAIT;
          winner_d   = pick_idx;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (!req_i[winner_q]) begin
          state_d = IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = GRANT;
          grant_d    = winner_oh;
          grant_id_d = winner_q;
          hold_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      GRANT: begin
        if (!req_i[winner_q] || hold_cnt_q == HOLD_LAST) begin
          grant_d    = '0;
          grant_id_d = '0;
          rr_ptr_d   = next_ptr;
          if (pick_valid) begin
            state_d    = WAIT;
            winner_d   = pick_idx;
            wait_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Age saturates one past MAX_LAT so the violation flag fires once per wait.
  always_comb begin
    age_d     = age_q;
    lat_err_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_i[i] || grant_q[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + 1'b1;
        if (age_q[i] == AGE_MAX - 1'b1) begin
          lat_err_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      winner_q   <= '0;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      lat_err_q  <= '0;
      age_q      <= '0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      lat_err_q  <= lat_err_d;
      age_q      <= age_d;
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign busy_o     = busy_q;
  assign lat_err_o  = lat_err_q;

endmodule

// File: tb/tb_arb_grant_ctrl.sv
// Directed bench for arb_grant_ctrl (defaults: 4 masters, MIN_LAT 2, MAX_LAT 5,
// MAX_HOLD 8); expectations are queued against edge numbers and checked on negedge.
module tb_arb_grant_ctrl;

  localparam int SEL_GRANT = 0;
  localparam int SEL_GID   = 1;
  localparam int SEL_BUSY  = 2;
  localparam int SEL_LAT   = 3;

  typedef struct {
    int         atEdge;
    string      tag;
    int         sel;
    logic [3:0] val;
  } exp_entry_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grantId;
  logic       busy;
  logic [3:0] latErr;

  exp_entry_t sb[$];
  int         cyc = 0;
  int         base = 0;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  arb_grant_ctrl #(
    .NUM_REQ  (4),
    .MIN_LAT  (2),
    .MAX_LAT  (5),
    .MAX_HOLD (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .grant_o    (grant),
    .grant_id_o (grantId),
    .busy_o     (busy),
    .lat_err_o  (latErr)
  );

  function automatic logic [3:0] observe(input int sel);
    case (sel)
      SEL_GRANT: return grant;
      SEL_GID:   return {2'b00, grantId};
      SEL_BUSY:  return {3'b000, busy};
      default:   return latErr;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int sel, input logic [3:0] expv);
    logic [3:0] obs;
    obs = observe(sel);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
  endtask

  task automatic expectAt(input int rel, input string tag, input int sel, input logic [3:0] v);
    exp_entry_t e;
    e.atEdge = base + rel;
    e.tag    = tag;
    e.sel    = sel;
    e.val    = v;
    sb.push_back(e);
  endtask

  // Compare everything due at the upcoming edge, then advance past that edge.
  task automatic tick();
    int i;
    @(negedge clk);
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].atEdge == cyc + 1) begin
        checkOutput(sb[i].tag, sb[i].sel, sb[i].val);
        sb.delete(i);
      end else begin
        i++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int t = 0; t < n; t++) tick();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(4'b0000);
    ticks(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b0000);
    tick();
    checkOutput("RST.grant", SEL_GRANT, 4'b0000);
    checkOutput("RST.gid", SEL_GID, 4'd0);
    checkOutput("RST.busy", SEL_BUSY, 4'd0);
    checkOutput("RST.lat", SEL_LAT, 4'b0000);
    tick();
    rst_n = 1'b1;

    // A: single request held six edges.
    doReset();
    base = cyc;
    applyStimulus(4'b0001);
    expectAt(1, "A.idleGrant", SEL_GRANT, 4'b0000);
    expectAt(1, "A.idleBusy", SEL_BUSY, 4'd0);
    expectAt(2, "A.waitBusy", SEL_BUSY, 4'd1);
    expectAt(2, "A.waitGrant", SEL_GRANT, 4'b0000);
    expectAt(3, "A.grant", SEL_GRANT, 4'b0001);
    expectAt(3, "A.gid", SEL_GID, 4'd0);
    expectAt(3, "A.busy", SEL_BUSY, 4'd1);
    expectAt(5, "A.noLat", SEL_LAT, 4'b0000);
    expectAt(7, "A.held", SEL_GRANT, 4'b0001);
    expectAt(8, "A.drop", SEL_GRANT, 4'b0000);
    expectAt(8, "A.idle", SEL_BUSY, 4'd0);
    expectAt(8, "A.lat", SEL_LAT, 4'b0000);
    ticks(6);
    applyStimulus(4'b0000);
    ticks(3);

    // B: request withdrawn during WAIT, pointer must stay at 0.
    doReset();
    base = cyc;
    applyStimulus(4'b0001);
    expectAt(2, "B.waitBusy", SEL_BUSY, 4'd1);
    expectAt(3, "B.abortBusy", SEL_BUSY, 4'd0);
    expectAt(3, "B.noGrant3", SEL_GRANT, 4'b0000);
    expectAt(4, "B.noGrant4", SEL_GRANT, 4'b0000);
    ticks(1);
    applyStimulus(4'b0000);
    ticks(3);
    base = cyc;
    applyStimulus(4'b0011);
    expectAt(3, "B.rrPtr0", SEL_GRANT, 4'b0001);
    expectAt(3, "B.gid0", SEL_GID, 4'd0);
    ticks(3);
    applyStimulus(4'b0000);
    ticks(2);

    // C: two requesters, hand-off to master 2, then pointer at 3.
    doReset();
    base = cyc;
    applyStimulus(4'b0101);
    expectAt(3, "C.grant0", SEL_GRANT, 4'b0001);
    expectAt(5, "C.hold0", SEL_GRANT, 4'b0001);
    expectAt(6, "C.handoffGrant", SEL_GRANT, 4'b0000);
    expectAt(6, "C.handoffBusy", SEL_BUSY, 4'd1);
    expectAt(7, "C.grant2", SEL_GRANT, 4'b0100);
    expectAt(7, "C.gid2", SEL_GID, 4'd2);
    expectAt(7, "C.lat2", SEL_LAT, 4'b0100);
    expectAt(8, "C.lat2Once", SEL_LAT, 4'b0000);
    expectAt(9, "C.hold2", SEL_GRANT, 4'b0100);
    expectAt(10, "C.release2", SEL_GRANT, 4'b0000);
    expectAt(10, "C.idle", SEL_BUSY, 4'd0);
    ticks(4);
    applyStimulus(4'b0100);
    ticks(4);
    applyStimulus(4'b0000);
    ticks(2);
    base = cyc;
    applyStimulus(4'b1011);
    expectAt(3, "C.rrPtr3Gid", SEL_GID, 4'd3);
    expectAt(3, "C.rrPtr3Grant", SEL_GRANT, 4'b1000);
    ticks(3);
    applyStimulus(4'b0000);
    ticks(2);

    // D: lone long request, forced release after eight sampled grant cycles.
    doReset();
    base = cyc;
    applyStimulus(4'b0010);
    expectAt(3, "D.grantFirst", SEL_GRANT, 4'b0010);
    expectAt(3, "D.gid", SEL_GID, 4'd1);
    expectAt(10, "D.grantEighth", SEL_GRANT, 4'b0010);
    expectAt(11, "D.forcedDrop", SEL_GRANT, 4'b0000);
    expectAt(11, "D.forcedIdle", SEL_BUSY, 4'd0);
    expectAt(12, "D.rewait", SEL_BUSY, 4'd1);
    expectAt(12, "D.noLat", SEL_LAT, 4'b0000);
    expectAt(13, "D.regrant", SEL_GRANT, 4'b0010);
    expectAt(20, "D.secondEighth", SEL_GRANT, 4'b0010);
    expectAt(21, "D.finalDrop", SEL_GRANT, 4'b0000);
    ticks(20);
    applyStimulus(4'b0000);
    ticks(2);

    // E: master 1 starved behind a held grant raises one latency pulse.
    doReset();
    base = cyc;
    applyStimulus(4'b0001);
    expectAt(3, "E.grant0", SEL_GRANT, 4'b0001);
    expectAt(8, "E.latQuiet", SEL_LAT, 4'b0000);
    expectAt(9, "E.latPulse", SEL_LAT, 4'b0010);
    expectAt(10, "E.latOnce", SEL_LAT, 4'b0000);
    expectAt(11, "E.handoff", SEL_GRANT, 4'b0000);
    expectAt(11, "E.latStill", SEL_LAT, 4'b0000);
    expectAt(12, "E.grant1", SEL_GRANT, 4'b0010);
    expectAt(12, "E.gid1", SEL_GID, 4'd1);
    ticks(2);
    applyStimulus(4'b0011);
    ticks(8);
    applyStimulus(4'b0010);
    ticks(3);
    applyStimulus(4'b0000);
    ticks(2);

    // F: asynchronous reset in the middle of a grant.
    doReset();
    base = cyc;
    applyStimulus(4'b0001);
    expectAt(3, "F.grant0", SEL_GRANT, 4'b0001);
    expectAt(4, "F.busyBefore", SEL_BUSY, 4'd1);
    ticks(4);
    rst_n = 1'b0;
    applyStimulus(4'b1000);
    #1;
    checkOutput("F.asyncGrant", SEL_GRANT, 4'b0000);
    checkOutput("F.asyncGid", SEL_GID, 4'd0);
    checkOutput("F.asyncBusy", SEL_BUSY, 4'd0);
    checkOutput("F.asyncLat", SEL_LAT, 4'b0000);
    ticks(2);
    rst_n = 1'b1;
    base = cyc;
    expectAt(1, "F.postIdle", SEL_BUSY, 4'd0);
    expectAt(2, "F.wait3", SEL_BUSY, 4'd1);
    expectAt(3, "F.grant3", SEL_GRANT, 4'b1000);
    expectAt(3, "F.gid3", SEL_GID, 4'd3);
    ticks(4);
    applyStimulus(4'b0000);
    ticks(2);

    while (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s: never checked, expected %h at edge %0d", sb[0].tag, sb[0].val, sb[0].atEdge);
      sb.delete(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arb_grant_ctrl.md
ARB_GRANT_CTRL -- requirements
Module: arb_grant_ctrl

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesting masters (2..8).
REQ-002 Parameter MIN_LAT, 2, minimum request-to-grant latency in cycles (2..MAX_LAT).
REQ-003 Parameter MAX_LAT, 5, maximum allowed request-to-grant latency in cycles.
REQ-004 Parameter MAX_HOLD, 8, maximum consecutive cycles one grant may be held.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req  in  NUM_REQ  per-master request, level, held until serviced.
REQ-008 grant  out  NUM_REQ  one-hot or zero grant, registered.
REQ-009 grant_id  out  $clog2(NUM_REQ)  index of current grant; 0 when none.
REQ-010 busy  out  1  high in WAIT or GRANT state.
REQ-011 lat_err  out  NUM_REQ  one-cycle pulse per master on latency violation.

Function
REQ-012 FSM states SHALL be IDLE, WAIT, GRANT; at most one grant bit high at any time.
REQ-013 IDLE: at an edge where any req bit is sampled high, pick the winner (round-robin from rr_ptr), latch it, enter WAIT.
REQ-014 WAIT SHALL last MIN_LAT-1 cycles, then enter GRANT with grant[winner] set so grant is sampled high exactly MIN_LAT edges after the request edge.
REQ-015 If req[winner] is sampled low during WAIT, the arbiter SHALL return to IDLE without granting; rr_ptr unchanged.
REQ-016 GRANT: grant held while req[winner] sampled high; grant SHALL drop at the edge req[winner] is sampled low.
REQ-017 Forced release: after MAX_HOLD edges sampling grant high, grant SHALL drop regardless of req.
REQ-018 On any release, rr_ptr SHALL become winner+1 (mod NUM_REQ); if other req bits are sampled high at the release edge, enter WAIT with a new winner, else IDLE.
REQ-019 Round-robin: search starts at rr_ptr, wraps past NUM_REQ-1 to 0; first requesting index wins.
REQ-020 A forced-released master still requesting SHALL be eligible only after all other requesters in rr order.
REQ-021 Per-master age counter (saturating, width for MAX_LAT+1): increments each edge req[i] is high and grant[i] low; clears when req[i] low or grant[i] high.
REQ-022 lat_err[i] SHALL pulse for one cycle when req[i] has been sampled high for MAX_LAT+1 consecutive edges with grant[i] never sampled high; no re-pulse until age clears.
REQ-023 grant_id and busy SHALL be registered and consistent with grant in the same cycle.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, grant=0, grant_id=0, busy=0, lat_err=0, rr_ptr=0, all age and hold counters 0.
REQ-025 Reset asserted mid-WAIT or mid-GRANT SHALL abandon the transaction; first arbitration after release of rst_n behaves as from power-up.

Structure
REQ-026 Package arb_pkg SHALL hold the state enum (IDLE, WAIT, GRANT) and default values of NUM_REQ, MIN_LAT, MAX_LAT, MAX_HOLD.
REQ-027 Round-robin selection SHALL be one combinational sub-module arb_rr_picker (inputs req mask, rr_ptr; outputs valid, index).
REQ-028 Compile-time check: MIN_LAT>=2, MIN_LAT<=MAX_LAT, MAX_HOLD>=1.

Verification
REQ-029 req[0]=1 sampled at edge 1, held 6 edges -> grant[0] sampled high at edge 3, grant_id=0, busy=1; drops at edge after req[0] low; lat_err=0.
REQ-030 req[0]=1 at edge 1, low at edge 2 -> no grant ever, state IDLE by edge 3, rr_ptr stays 0.
REQ-031 req[0] and req[2] high at edge 1 -> grant[0] at edge 3; req[0] dropped at edge 5 -> grant[2] sampled at edge 7, rr_ptr=3 after its release.
REQ-032 req[1] held 20 edges alone -> grant[1] exactly 8 sampled cycles, forced release, re-granted 2 edges later (no other requester).
REQ-033 req[0] granted and held, req[1] raised at edge k -> lat_err[1] single pulse after edge k+5; concurrent assertion req|->##[MIN_LAT:MAX_LAT] grant flags same cycle.
REQ-034 rst_n pulled low mid-GRANT -> grant, busy, lat_err 0 immediately (asynchronous); after release, req[3] alone granted MIN_LAT edges later.
